// File: rtl/btn_symbol_capture.sv
// Player button front end: synchronize, debounce, and turn each clean single-button
// press-and-release into a 2-bit symbol on a valid/ready handshake, with error and timeout pulses.
module btn_symbol_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       arm,
    input  logic       sym_ready,
    output logic       sym_valid,
    output logic [1:0] sym,
    output logic       error,
    output logic       timeout
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic            TO_ENABLED = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, DOWN, EMIT, RELEASE} state_t;

    state_t          state;
    logic [2:0]      sync_meta;
    logic [2:0]      sync;
    logic [2:0]      sync_q;
    logic [2:0]      db;
    logic [DB_W-1:0] db_cnt;
    logic [TO_W-1:0] to_cnt;

    logic            db_clr;
    logic            db_one_hot;
    logic            db_multi;
    logic [1:0]      db_code;
    logic [2:0]      sym_one_hot;
    logic            to_run;

    // Vector classification shared by the FSM
    always_comb begin
        db_clr      = (sync == db) || (sync != sync_q);
        db_one_hot  = (db == 3'b001) || (db == 3'b010) || (db == 3'b100);
        db_multi    = (db != 3'b000) && !db_one_hot;
        db_code     = 2'b00;
        if (db[1]) db_code = 2'b01;
        if (db[2]) db_code = 2'b10;
        sym_one_hot = 3'b001 << sym;
        to_run      = TO_ENABLED && (state == IDLE) && arm && (db == 3'b000);
    end

    // Two-flop synchronizer plus whole-vector debounce
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 3'b000;
            sync      <= 3'b000;
            sync_q    <= 3'b000;
            db        <= 3'b000;
            db_cnt    <= '0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
            sync_q    <= sync;
            if (db_clr) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Inactivity timer; restarts after every pulse so it repeats while still idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (!to_run) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (to_cnt == TO_LAST) begin
            to_cnt  <= '0;
            timeout <= 1'b1;
        end else begin
            to_cnt  <= to_cnt + TO_W'(1);
            timeout <= 1'b0;
        end
    end

    // Press / release / handshake sequencing
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sym_valid <= 1'b0;
            sym       <= 2'b00;
            error     <= 1'b0;
        end else begin
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arm && db_one_hot) begin
                        sym   <= db_code;
                        state <= DOWN;
                    end else if (arm && db_multi) begin
                        error <= 1'b1;
                        state <= RELEASE;
                    end
                end
                DOWN: begin
                    if (db == 3'b000) begin
                        sym_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (db_multi) begin
                        error <= 1'b1;
                        state <= RELEASE;
                    end else if (!arm || (db != sym_one_hot)) begin
                        state <= RELEASE;
                    end
                end
                EMIT: begin
                    if (sym_ready) begin
                        sym_valid <= 1'b0;
                        state     <= (db == 3'b000) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (db == 3'b000) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_symbol_capture.sv
// Self-checking bench for btn_symbol_capture: directed scenarios plus randomized press sequences
// checked against an event-level model of which symbols and errors each press should produce.
module tb_btn_symbol_capture;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 8;

    logic       clock;
    logic       rst_n;
    logic [2:0] btn;
    logic       arm;
    logic       sym_ready;
    logic       sym_valid;
    logic [1:0] sym;
    logic       error;
    logic       timeout;
    logic       sym_valid0;
    logic [1:0] sym0;
    logic       error0;
    logic       timeout0;

    int         n_pass;
    int         n_total;
    int         acc_cnt;
    int         err_cnt;
    int         to_cnt;
    int         to0_cnt;
    logic [1:0] acc_q[$];
    logic       prev_hold;
    logic [1:0] prev_sym;

    btn_symbol_capture #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(rst_n), .btn(btn), .arm(arm), .sym_ready(sym_ready),
        .sym_valid(sym_valid), .sym(sym), .error(error), .timeout(timeout)
    );

    btn_symbol_capture #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(0)) dut0 (
        .clock(clock), .reset(rst_n), .btn(btn), .arm(arm), .sym_ready(sym_ready),
        .sym_valid(sym_valid0), .sym(sym0), .error(error0), .timeout(timeout0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Passive monitor: records accepted symbols, pulse counts and handshake stability
    always @(negedge clock) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                n_total++;
                if (!(sym_valid === 1'b1 && sym === prev_sym))
                    $display("FAIL hold_stable: valid=%b sym=%0d required valid=1 sym=%0d", sym_valid, sym, prev_sym);
                else n_pass++;
            end
            if (error || timeout) begin
                n_total++;
                if (error && timeout) $display("FAIL err_to_overlap: error=1 timeout=1 required not both");
                else n_pass++;
            end
            if (sym_valid && sym_ready) begin
                acc_q.push_back(sym);
                acc_cnt++;
            end
            if (error) err_cnt++;
            if (timeout) to_cnt++;
            if (timeout0) to0_cnt++;
            prev_hold = sym_valid && !sym_ready;
            prev_sym  = sym;
        end
    end

    // Reference: a press yields symbol = index of its only button, or -1 (error) for a multi press
    function automatic int model_symbol(input logic [2:0] v);
        int ones = 0;
        int idx  = -1;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                ones++;
                idx = i;
            end
        end
        return (ones == 1) ? idx : -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        btn = v;
        repeat (n) tick();
    endtask

    task automatic wait_accept(input int a0, input logic rand_ready, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (rand_ready) sym_ready = 1'($urandom_range(0, 1));
            tick();
            if (acc_cnt > a0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn = 3'b000; arm = 1'b0; sym_ready = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({sym_valid, sym, error, timeout} !== 5'b0)
            $display("FAIL reset_outputs: got %b required 00000", {sym_valid, sym, error, timeout});
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        int a0, e0, first, beats;
        arm = 1'b1; sym_ready = 1'b1;
        hold(3'b000, 10);
        a0 = acc_cnt; e0 = err_cnt;
        hold(3'b001, 20);
        btn = 3'b000;
        first = -1; beats = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (sym_valid) begin
                if (first < 0) first = i;
                beats++;
            end
        end
        n_total++;
        if (first != 7) $display("FAIL release_latency: got %0d required 7", first); else n_pass++;
        n_total++;
        if (beats != 1) $display("FAIL single_beat: got %0d required 1", beats); else n_pass++;
        n_total++;
        if (acc_cnt - a0 != 1 || acc_q[$] !== 2'd0)
            $display("FAIL clean_symbol: count=%0d sym=%0d required 1 and 0", acc_cnt - a0, acc_q[$]);
        else n_pass++;
        n_total++;
        if (err_cnt != e0) $display("FAIL clean_no_error: got %0d required 0", err_cnt - e0); else n_pass++;
    endtask

    task automatic test_bounce_hold();
        int  a0;
        logic seen;
        sym_ready = 1'b0; arm = 1'b1;
        a0 = acc_cnt;
        repeat (3) begin
            hold(3'b100, 3);
            hold(3'b000, 3);
        end
        hold(3'b100, 15);
        btn = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (sym_valid) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL bounce_valid_timeout: valid=0 required 1"); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if ({sym_valid, sym} !== 3'b110)
                $display("FAIL stall_hold_%0d: got %b required 110", i, {sym_valid, sym});
            else n_pass++;
            tick();
        end
        sym_ready = 1'b1;
        tick();
        n_total++;
        if (sym_valid !== 1'b0) $display("FAIL valid_drop: got %b required 0", sym_valid); else n_pass++;
        n_total++;
        if (acc_cnt - a0 != 1 || acc_q[$] !== 2'd2)
            $display("FAIL bounce_symbol: count=%0d sym=%0d required 1 and 2", acc_cnt - a0, acc_q[$]);
        else n_pass++;
    endtask

    task automatic test_multi();
        int a0, e0;
        sym_ready = 1'b1; arm = 1'b1;
        a0 = acc_cnt; e0 = err_cnt;
        hold(3'b011, 12);
        n_total++;
        if (err_cnt - e0 != 1) $display("FAIL multi_error: got %0d required 1", err_cnt - e0); else n_pass++;
        hold(3'b001, 12);
        hold(3'b000, 15);
        n_total++;
        if (err_cnt - e0 != 1) $display("FAIL multi_single_error: got %0d required 1", err_cnt - e0); else n_pass++;
        n_total++;
        if (acc_cnt != a0) $display("FAIL multi_no_symbol: got %0d required 0", acc_cnt - a0); else n_pass++;
    endtask

    task automatic test_timeout();
        int t0;
        arm = 1'b0; btn = 3'b000;
        repeat (5) tick();
        arm = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_total++;
            if (timeout !== ((i == 8) || (i == 16)))
                $display("FAIL timeout_cycle_%0d: got %b required %b", i, timeout, (i == 8) || (i == 16));
            else n_pass++;
            n_total++;
            if (timeout0 !== 1'b0) $display("FAIL timeout_disabled_%0d: got %b required 0", i, timeout0);
            else n_pass++;
        end
        arm = 1'b0;
        t0 = to_cnt;
        repeat (20) tick();
        n_total++;
        if (to_cnt != t0) $display("FAIL timeout_unarmed: got %0d required 0", to_cnt - t0); else n_pass++;
    endtask

    task automatic test_arm_drop();
        int   a0;
        logic ok;
        sym_ready = 1'b1; arm = 1'b1;
        a0 = acc_cnt;
        hold(3'b010, 12);
        arm = 1'b0;
        hold(3'b000, 15);
        n_total++;
        if (acc_cnt != a0) $display("FAIL arm_drop_no_symbol: got %0d required 0", acc_cnt - a0); else n_pass++;
        arm = 1'b1;
        hold(3'b010, 12);
        btn = 3'b000;
        wait_accept(a0, 1'b0, ok);
        n_total++;
        if (!ok || acc_q[$] !== 2'd1)
            $display("FAIL rearm_symbol: accepted=%b sym=%0d required 1 and 1", ok, acc_q[$]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_emit();
        int   a0;
        logic seen, ok;
        sym_ready = 1'b0; arm = 1'b1;
        hold(3'b001, 12);
        btn = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (sym_valid) seen = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if (!seen || {sym_valid, sym, error, timeout} !== 5'b0)
            $display("FAIL reset_mid_emit: seen=%b outputs=%b required 1 and 00000", seen,
                     {sym_valid, sym, error, timeout});
        else n_pass++;
        repeat (3) tick();
        rst_n = 1'b1;
        sym_ready = 1'b1;
        hold(3'b000, 3);
        a0 = acc_cnt;
        hold(3'b001, 12);
        btn = 3'b000;
        wait_accept(a0, 1'b0, ok);
        n_total++;
        if (!ok || acc_q[$] !== 2'd0)
            $display("FAIL post_reset_symbol: accepted=%b sym=%0d required 1 and 0", ok, acc_q[$]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] v, g;
        int         a0, e0, exp_sym;
        logic       ok;
        arm = 1'b1; sym_ready = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) < 3) v = 3'b001 << $urandom_range(0, 2);
            else begin
                v = 3'b111;
                do v = 3'($urandom_range(3, 7)); while (model_symbol(v) >= 0);
            end
            exp_sym = model_symbol(v);
            a0 = acc_cnt; e0 = err_cnt;
            g = 3'($urandom_range(1, 7));
            hold(g, $urandom_range(1, DB - 1));
            hold(3'b000, $urandom_range(1, DB - 1));
            hold(v, $urandom_range(DB + 4, 20));
            btn = 3'b000;
            if (exp_sym >= 0) begin
                wait_accept(a0, 1'b1, ok);
                n_total++;
                if (!ok || acc_cnt - a0 != 1 || acc_q[$] !== 2'(exp_sym) || err_cnt != e0)
                    $display("FAIL rand_press_%0d: v=%b count=%0d sym=%0d err=%0d required 1 %0d 0",
                             n, v, acc_cnt - a0, acc_q[$], err_cnt - e0, exp_sym);
                else n_pass++;
            end else begin
                for (int i = 0; i < DB + 8; i++) begin
                    sym_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                n_total++;
                if (err_cnt - e0 != 1 || acc_cnt != a0)
                    $display("FAIL rand_multi_%0d: v=%b err=%0d count=%0d required 1 0",
                             n, v, err_cnt - e0, acc_cnt - a0);
                else n_pass++;
            end
            sym_ready = 1'b0;
            hold(3'b000, 4);
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0; acc_cnt = 0; err_cnt = 0; to_cnt = 0; to0_cnt = 0;
        prev_hold = 1'b0; prev_sym = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce_hold();
        test_multi();
        test_timeout();
        test_arm_drop();
        test_reset_mid_emit();
        test_random();
        n_total++;
        if (to0_cnt != 0) $display("FAIL disabled_timeout_total: got %0d required 0", to0_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
